// File: rtl/clock_group_pkg.sv
// clock_group_pkg: shared state encoding and sizing helper for the clock-group reset sequencer
package clock_group_pkg;
    // ACK is kept for encoding compatibility; the ack is issued on the RLEAD exit edge.
    typedef enum logic [2:0] {SYNC, LEAD, GAP, IDLE, HOLD, RLEAD, ACK} state_t;
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/clock_group_reset_sequencer_if.sv
// clock_group_reset_sequencer_if: per-member reset handshake and sequencer status bundle
interface clock_group_reset_sequencer_if #(parameter int NUM_MEMBERS = 4);
    logic [NUM_MEMBERS-1:0] member_reset_req;
    logic [NUM_MEMBERS-1:0] member_reset_ack;
    logic [NUM_MEMBERS-1:0] member_reset;
    logic [NUM_MEMBERS-1:0] member_clk_en;
    logic                   seq_busy;
    logic                   seq_done;
    modport master (
        input  member_reset_req,
        output member_reset_ack, member_reset, member_clk_en, seq_busy, seq_done
    );
    modport slave (
        output member_reset_req,
        input  member_reset_ack, member_reset, member_clk_en, seq_busy, seq_done
    );
endinterface

// File: rtl/clock_group_reset_sequencer_reset_sync.sv
// reset_sync: asynchronous-assert, synchronous-deassert reset synchroniser
module reset_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clock,
    input  logic reset_n,
    output logic reset_n_sync
);
    logic [SYNC_STAGES-1:0] sr;
    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) sr <= '0;
        else          sr <= {sr[SYNC_STAGES-2:0], 1'b1};
    assign reset_n_sync = sr[SYNC_STAGES-1];
endmodule

// File: rtl/clock_group_reset_sequencer.sv
// clock_group_reset_sequencer: staggered power-up release and per-member re-reset for one clock group
module clock_group_reset_sequencer
    import clock_group_pkg::*;
#(
    parameter int NUM_MEMBERS    = 4,
    parameter int SYNC_STAGES    = 2,
    parameter int STAGGER_CYCLES = 8,
    parameter int CLKEN_LEAD     = 2
) (
    input logic                           clock,
    input logic                           reset_n,
    clock_group_reset_sequencer_if.master bus
);
    localparam int CNT_W = $clog2(STAGGER_CYCLES + 1);
    localparam int IW    = clog2_min1(NUM_MEMBERS);
    localparam logic [CNT_W-1:0] LEAD_LD = CNT_W'(CLKEN_LEAD - 1);
    localparam logic [CNT_W-1:0] GAP_LD  = CNT_W'(STAGGER_CYCLES - 1);
    state_t                 state, state_d;
    logic [CNT_W-1:0]       cnt, cnt_d;
    logic [IW-1:0]          idx, idx_d, sel;
    logic [NUM_MEMBERS-1:0] rst_q, rst_d, en_q, en_d, ack_q, ack_d;
    logic                   busy_q, done_q, done_d, found, last, rst_sync_n;
    reset_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clock        (clock),
        .reset_n      (reset_n),
        .reset_n_sync (rst_sync_n)
    );
    always_comb begin
        found = 1'b0;
        sel   = '0;
        for (int k = NUM_MEMBERS - 1; k >= 0; k--)
            if (bus.member_reset_req[k] && !ack_q[k]) begin
                found = 1'b1;
                sel   = IW'(k);
            end
    end
    assign last = idx == IW'(NUM_MEMBERS - 1);
    // The final GAP lasts one cycle so seq_done lands just after the last reset falls.
    always_comb begin
        state_d = state;
        cnt_d   = (cnt == '0) ? cnt : cnt - 1'b1;
        idx_d   = idx;
        rst_d   = rst_q;
        en_d    = en_q;
        ack_d   = ack_q & bus.member_reset_req;
        done_d  = done_q;
        unique case (state)
            SYNC: begin
                state_d = LEAD;
                idx_d   = '0;
                cnt_d   = LEAD_LD;
                en_d[0] = 1'b1;
            end
            LEAD: if (cnt == '0) begin
                state_d    = GAP;
                cnt_d      = last ? '0 : GAP_LD;
                rst_d[idx] = 1'b0;
            end
            GAP: if (cnt == '0) begin
                if (last) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d     = LEAD;
                    idx_d       = idx + 1'b1;
                    cnt_d       = LEAD_LD;
                    en_d[idx_d] = 1'b1;
                end
            end
            IDLE: if (found) begin
                state_d    = HOLD;
                idx_d      = sel;
                cnt_d      = GAP_LD;
                rst_d[sel] = 1'b1;
                en_d[sel]  = 1'b0;
            end
            HOLD: if (cnt == '0) begin
                state_d   = RLEAD;
                cnt_d     = LEAD_LD;
                en_d[idx] = 1'b1;
            end
            RLEAD: if (cnt == '0) begin
                state_d    = IDLE;
                rst_d[idx] = 1'b0;
                ack_d[idx] = 1'b1;
            end
            default: state_d = SYNC;
        endcase
    end
    always_ff @(posedge clock or negedge rst_sync_n)
        if (!rst_sync_n) begin
            state  <= SYNC;
            cnt    <= '0;
            idx    <= '0;
            rst_q  <= '1;
            en_q   <= '0;
            ack_q  <= '0;
            busy_q <= 1'b1;
            done_q <= 1'b0;
        end else begin
            state  <= state_d;
            cnt    <= cnt_d;
            idx    <= idx_d;
            rst_q  <= rst_d;
            en_q   <= en_d;
            ack_q  <= ack_d;
            busy_q <= state_d != IDLE;
            done_q <= done_d;
        end
    assign bus.member_reset     = rst_q;
    assign bus.member_clk_en    = en_q;
    assign bus.member_reset_ack = ack_q;
    assign bus.seq_busy         = busy_q;
    assign bus.seq_done         = done_q;
endmodule
